adc_responder: RTL and testbench

- Synthesizable slave-side model of the serial ADC that the design's ADC receiver drives: it answers CONVST/SCK/SDI and returns a 12-bit result on SDO.
- Used in loopback benches and FPGA self-test builds in place of the physical converter.
- Emulates conversion busy time, captures the 6-bit config word shifted in on SDI, and shifts out the sample latched at conversion start, MSB first.
- All pins are sampled on i_clk, which must run at least 4x faster than SCK.

---
 rtl/adc_responder_if.sv | 12 +
 rtl/adc_responder.sv | 176 +++++++++++++++++
 tb/tb_adc_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/adc_responder_if.sv
// Serial pin bundle between an ADC receiver (master) and the converter
// or its responder model (slave): CONVST, SCK and SDI go to the converter,
// and SDO comes back.
interface adc_responder_if;
  logic convst;
  logic sck;
  logic sdi;
  logic sdo;

  modport master (output convst, output sck, output sdi, input sdo);
  modport slave  (input convst, input sck, input sdi, output sdo);
endinterface

// File: rtl/adc_responder.sv
// Slave-side model of the serial ADC. It emulates the conversion busy time,
// captures the config word shifted in on SDI, and returns the sample that was
// latched at conversion start on SDO, MSB first. All pins are sampled on
// i_clk, which must run at least 4x faster than SCK.
// Optional build macro: ADC_RESPONDER_PATTERN_EN replaces i_sample with an
// internal counter that increments at each conversion start.
module adc_responder #(
  parameter int CONV_CYCLES = 50,
  parameter int DATA_BITS   = 12,
  parameter int CFG_BITS    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  adc_responder_if.slave       adc,
  input  logic [DATA_BITS-1:0] i_sample,
  output logic                 o_busy,
  output logic [CFG_BITS-1:0]  o_config,
  output logic                 o_config_dv,
  output logic                 o_xfer_done
);
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int FW = $clog2(CFG_BITS + 1);

  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] CONV_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [FW-1:0] CFG_LAST  = FW'(CFG_BITS - 1);
  localparam logic [FW-1:0] CFG_FULL  = FW'(CFG_BITS);
  localparam logic [FW-1:0] CFG_ONE   = FW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_WAIT, S_SHIFT} state_t;

  state_t               state, state_d;
  logic                 convst_q, sck_q;
  logic [CW-1:0]        conv_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [FW-1:0]        cfg_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CFG_BITS-1:0]  cfg_shift;
  logic [DATA_BITS-1:0] latch_val;
  logic                 sdo_q;

  // Edges compare the live pin with its one-cycle-old copy.
  logic convst_rise, sck_rise, sck_fall;
  assign convst_rise = adc.convst & ~convst_q;
  assign sck_rise    = adc.sck & ~sck_q;
  assign sck_fall    = ~adc.sck & sck_q;

  // Per-cycle events decoded from state; a CONVST rise always wins.
  logic conv_start, shift_go, cfg_cap, data_fall;

  assign adc.sdo = sdo_q;

`ifdef ADC_RESPONDER_PATTERN_EN
  logic [DATA_BITS-1:0] pat_cnt;
  assign latch_val = pat_cnt;

  // Test pattern advances once per conversion start and wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst)           pat_cnt <= '0;
    else if (conv_start) pat_cnt <= pat_cnt + DATA_BITS'(1);
  end
`else
  assign latch_val = i_sample;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state and event decode.
  always_comb begin
    state_d    = state;
    conv_start = 1'b0;
    shift_go   = 1'b0;
    cfg_cap    = 1'b0;
    data_fall  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (convst_rise) begin
          conv_start = 1'b1;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        if (conv_cnt == '0) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (convst_rise) begin
          conv_start = 1'b1;
          state_d    = S_CONV;
        end else if (!convst_q) begin
          shift_go = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (convst_rise) begin
          conv_start = 1'b1;
          state_d    = S_CONV;
        end else begin
          cfg_cap   = sck_rise && (cfg_cnt < CFG_FULL);
          data_fall = sck_fall;
          if (sck_fall && bit_cnt == BIT_LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: edge flops, counters, shifters and output pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      convst_q    <= 1'b0;
      sck_q       <= 1'b0;
      conv_cnt    <= '0;
      bit_cnt     <= '0;
      cfg_cnt     <= '0;
      shift_reg   <= '0;
      cfg_shift   <= '0;
      sdo_q       <= 1'b0;
      o_busy      <= 1'b0;
      o_config    <= '0;
      o_config_dv <= 1'b0;
      o_xfer_done <= 1'b0;
    end else begin
      convst_q    <= adc.convst;
      sck_q       <= adc.sck;
      o_config_dv <= 1'b0;
      o_xfer_done <= 1'b0;

      if (conv_start) begin
        // New conversion discards any partial transfer or config word.
        shift_reg <= latch_val;
        conv_cnt  <= CONV_LAST;
        o_busy    <= 1'b1;
        sdo_q     <= 1'b0;
        bit_cnt   <= '0;
        cfg_cnt   <= '0;
      end else if (state == S_CONV) begin
        if (conv_cnt == '0) o_busy   <= 1'b0;
        else                conv_cnt <= conv_cnt - CONV_ONE;
      end

      if (shift_go) begin
        sdo_q   <= shift_reg[DATA_BITS-1];
        bit_cnt <= '0;
        cfg_cnt <= '0;
      end

      if (cfg_cap) begin
        cfg_shift <= {cfg_shift[CFG_BITS-2:0], adc.sdi};
        cfg_cnt   <= cfg_cnt + CFG_ONE;
        if (cfg_cnt == CFG_LAST) begin
          o_config    <= {cfg_shift[CFG_BITS-2:0], adc.sdi};
          o_config_dv <= 1'b1;
        end
      end

      if (data_fall) begin
        if (bit_cnt == BIT_LAST) begin
          sdo_q       <= 1'b0;
          o_xfer_done <= 1'b1;
        end else begin
          shift_reg <= shift_reg << 1;
          sdo_q     <= shift_reg[DATA_BITS-2];
          bit_cnt   <= bit_cnt + BIT_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_responder.sv
// Directed plus randomized bench for adc_responder. The reference model
// tracks what the converter should report (latched sample, last complete
// config word, pulse counts) straight from the pin-level protocol.
module tb_adc_responder;
  localparam int CONV_CYCLES = 50;
  localparam int DATA_BITS   = 12;
  localparam int CFG_BITS    = 6;
  localparam int HALF_SCK    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample;
  logic        busy, cfg_dv, xfer_done;
  logic [5:0]  config_o;

  adc_responder_if bus();

  adc_responder #(.CONV_CYCLES(CONV_CYCLES), .DATA_BITS(DATA_BITS), .CFG_BITS(CFG_BITS)) dut (
    .i_clk(clk), .i_rst(rst), .adc(bus.slave), .i_sample(sample),
    .o_busy(busy), .o_config(config_o), .o_config_dv(cfg_dv), .o_xfer_done(xfer_done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int dv_cnt = 0, done_cnt = 0;

  // Reference model state.
  int          exp_config = 0;
  int          exp_word   = 0;
  int          pat_cnt    = 0;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (cfg_dv === 1'b1)    dv_cnt++;
    if (xfer_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise CONVST, measure the busy window, return once busy has dropped.
  // Optionally wiggle SCK while busy to show it is ignored.
  task automatic start_conv(input logic [11:0] s, input bit wiggle);
    int n = 0;
    bit ended = 0;
    sample = s;
`ifdef ADC_RESPONDER_PATTERN_EN
    exp_word = pat_cnt;
    pat_cnt  = (pat_cnt + 1) % 4096;
`else
    exp_word = int'(s);
`endif
    bus.convst = 1'b1;
    for (int t = 0; t < 200 && !ended; t++) begin
      @(negedge clk);
      if (t == 2) bus.convst = 1'b0;
      if (busy) begin
        n++;
        if (wiggle) begin
          bus.sck = (t % 4) >= 2;
          bus.sdi = 1'($urandom);
        end
      end else if (n > 0) begin
        bus.sck = 1'b0;
        ended = 1;
      end
    end
    chk("busy_len", n, CONV_CYCLES);
  endtask

  // Run `periods` SCK periods, driving cfg MSB first and collecting SDO.
  task automatic xfer(input int periods, input logic [5:0] cfg, output int got);
    logic [5:0] c;
    c = cfg;
    got = 0;
    for (int i = 0; i < periods; i++) begin
      @(negedge clk);
      bus.sdi = (i < CFG_BITS) ? c[CFG_BITS-1-i] : 1'($urandom);
      bus.sck = 1'b1;
      repeat (HALF_SCK) @(negedge clk);
      got = (got << 1) | int'(bus.sdo);
      bus.sck = 1'b0;
      repeat (HALF_SCK) @(negedge clk);
    end
  endtask

  // Full conversion + 12-bit transfer, checked against the model.
  task automatic full_cycle(input string tag, input logic [11:0] s, input logic [5:0] cfg, input bit wiggle);
    int got, dv0, dn0;
    start_conv(s, wiggle);
    dv0 = dv_cnt; dn0 = done_cnt;
    xfer(DATA_BITS, cfg, got);
    exp_config = int'(cfg);
    chk({tag, "_data"}, got, exp_word);
    chk({tag, "_done"}, done_cnt - dn0, 1);
    chk({tag, "_dv"}, dv_cnt - dv0, 1);
    chk({tag, "_cfg"}, int'(config_o), exp_config);
    chk({tag, "_sdo_idle"}, int'(bus.sdo), 0);
  endtask

  initial begin
    int got, dv0, dn0, bad;
    rst = 1'b1; sample = '0;
    bus.convst = 1'b0; bus.sck = 1'b0; bus.sdi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sdo", int'(bus.sdo), 0);
    chk("rst_cfg", int'(config_o), 0);
    chk("rst_pulses", int'({cfg_dv, xfer_done}), 0);

    // Known sample and config word.
    full_cycle("t1", 12'hA5C, 6'b100000, 0);

    // Short transfer aborted after 3 periods: config must not change.
    start_conv(12'h3C7, 0);
    dv0 = dv_cnt;
    xfer(3, 6'b011111, got);
    start_conv(12'h5A5, 0);
    chk("t2_abort_dv", dv_cnt - dv0, 0);
    chk("t2_cfg_kept", int'(config_o), exp_config);
    xfer(DATA_BITS, 6'b000111, got);
    exp_config = 7;
    chk("t2_data", got, exp_word);

    // SCK toggling in IDLE and during CONV.
    dv0 = dv_cnt; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.sck = i[1]; bus.sdi = 1'($urandom);
      if (bus.sdo !== 1'b0 || busy !== 1'b0) bad++;
    end
    bus.sck = 1'b0;
    chk("t3_idle_quiet", bad, 0);
    chk("t3_idle_dv", dv_cnt - dv0, 0);
    full_cycle("t3", 12'h6E1, 6'b010101, 1);

    // Abort after 5 SCK periods with a new sample.
    start_conv(12'hFFF, 0);
    dv0 = dv_cnt; dn0 = done_cnt;
    xfer(5, 6'b111111, got);
    start_conv(12'h123, 0);
    chk("t4_abort_dv", dv_cnt - dv0, 0);
    chk("t4_abort_done", done_cnt - dn0, 0);
    xfer(DATA_BITS, 6'b001100, got);
    exp_config = 6'b001100;
    chk("t4_data", got, exp_word);
    chk("t4_cfg", int'(config_o), exp_config);

    // Reset mid-SHIFT.
    start_conv(12'h9B2, 0);
    xfer(4, 6'b110011, got);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_config = 0; pat_cnt = 0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_sdo", int'(bus.sdo), 0);
    chk("t5_cfg", int'(config_o), 0);
    chk("t5_pulses", int'({cfg_dv, xfer_done}), 0);
    full_cycle("t5", 12'h0F0, 6'b101010, 0);

    // Randomized conversions.
    for (int i = 0; i < 8; i++)
      full_cycle("rnd", 12'($urandom), 6'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
